// File: rtl/nanorv32_periph_bridge_if.sv
// CPU request/response channel plus shared peripheral bus for the nanorv32 peripheral bridge.
// Latency: none (signal bundle only).
// Backpressure: cpu_req_ready throttles requests; responses and slave enables are never stalled.
interface nanorv32_periph_bridge_if #(
    parameter int NSLV = 4
);
    logic                cpu_req_valid;
    logic                cpu_req_ready;
    logic [15:0]         cpu_req_addr;
    logic [3:0]          cpu_req_bytesel;
    logic [31:0]         cpu_req_wdata;
    logic                cpu_rsp_valid;
    logic [31:0]         cpu_rsp_rdata;
    logic                cpu_rsp_err;
    logic [11:0]         bus_periph_addr;
    logic [3:0]          bus_periph_bytesel;
    logic [31:0]         bus_periph_din;
    logic [NSLV-1:0]     bus_periph_en;
    logic [32*NSLV-1:0]  periph_bus_dout;
    logic [NSLV-1:0]     periph_bus_ready_nxt;

    // Bridge side.
    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_bytesel, cpu_req_wdata,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
        output bus_periph_addr, bus_periph_bytesel, bus_periph_din, bus_periph_en,
        input  periph_bus_dout, periph_bus_ready_nxt
    );

    // CPU plus peripheral side.
    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_bytesel, cpu_req_wdata,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err,
        input  bus_periph_addr, bus_periph_bytesel, bus_periph_din, bus_periph_en,
        output periph_bus_dout, periph_bus_ready_nxt
    );
endinterface

// File: rtl/nanorv32_periph_bridge.sv
// Single-outstanding CPU to peripheral bridge with fixed addr[13:12] slave decode and wait timeout.
// Latency: zero-wait slave responds 3 cycles after accept, decode error 1 cycle, timeout TIMEOUT+1.
// Backpressure: cpu_req_ready only in IDLE; the response is a one-cycle pulse with no stall.
module nanorv32_periph_bridge #(
    parameter int TIMEOUT = 16,
    parameter int NSLV    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nanorv32_periph_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [11:0]     offs_q, offs_d;
    logic [3:0]      bsel_q, bsel_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            sel_ready;
    logic [31:0]     sel_dout;
    logic [NSLV-1:0] en_dec;
    logic            decode_err;

    // Only the selected slave's ready and data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_dout  = '0;
        en_dec    = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == 2'(i)) begin
                sel_ready = bus.periph_bus_ready_nxt[i];
                sel_dout  = bus.periph_bus_dout[32*i +: 32];
                en_dec[i] = 1'b1;
            end
        end
    end

    assign decode_err = (bus.cpu_req_addr[15:14] != 2'b00) ||
                        (int'(bus.cpu_req_addr[13:12]) >= NSLV);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        offs_d  = offs_q;
        bsel_d  = bsel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_valid) begin
                    sel_d   = bus.cpu_req_addr[13:12];
                    offs_d  = bus.cpu_req_addr[11:0];
                    bsel_d  = bus.cpu_req_bytesel;
                    wdata_d = bus.cpu_req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = decode_err;
                    state_d = decode_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // Ready on the last wait cycle still wins over the timeout.
                if (sel_ready) begin
                    state_d = DATA;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                rdata_d = (bsel_q == 4'h0) ? sel_dout : 32'h0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            offs_q  <= '0;
            bsel_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            offs_q  <= offs_d;
            bsel_q  <= bsel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state_q so an async reset drops en at once.
    assign bus.cpu_req_ready      = (state_q == IDLE);
    assign bus.cpu_rsp_valid      = (state_q == RESP);
    assign bus.cpu_rsp_rdata      = rdata_q;
    assign bus.cpu_rsp_err        = err_q;
    assign bus.bus_periph_en      = (state_q == ACCESS) ? en_dec : '0;
    assign bus.bus_periph_addr    = offs_q;
    assign bus.bus_periph_bytesel = bsel_q;
    assign bus.bus_periph_din     = wdata_q;

endmodule

// File: tb/tb_nanorv32_periph_bridge.sv
// Randomized bench for nanorv32_periph_bridge against a transaction-level outcome model.
module tb_nanorv32_periph_bridge;

    localparam int TIMEOUT = 16;
    localparam int NSLV    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nanorv32_periph_bridge_if #(.NSLV(NSLV)) bif ();

    nanorv32_periph_bridge #(.TIMEOUT(TIMEOUT), .NSLV(NSLV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        bif.cpu_req_valid        = 1'b0;
        bif.cpu_req_addr         = '0;
        bif.cpu_req_bytesel      = '0;
        bif.cpu_req_wdata        = '0;
        bif.periph_bus_ready_nxt = '0;
        bif.periph_bus_dout      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a negedge while the bridge is idle; leaves at the negedge after the response.
    task automatic run_txn(input logic [15:0] addr, input logic [3:0] bs, input logic [31:0] wd,
                           input int delay, input logic [31:0] rd_word);
        int          exp_lat, exp_en, sel, t, en_cnt;
        logic [31:0] exp_rdata, got_rdata, noise;
        logic        exp_err, got_err, done, fire, rdy_prev;
        logic [NSLV-1:0] en_obs;
        logic        rsp_obs, ready_obs;
        logic [11:0] baddr_obs;
        logic [3:0]  bbs_obs;
        logic [31:0] bdin_obs;

        sel = int'(addr[13:12]);
        if (addr[15:14] != 2'b00) begin
            exp_lat = 1; exp_en = 0; exp_err = 1'b1; exp_rdata = 32'h0;
        end else if (delay < TIMEOUT) begin
            exp_lat = delay + 3; exp_en = delay + 1; exp_err = 1'b0;
            exp_rdata = (bs == 4'h0) ? rd_word : 32'h0;
        end else begin
            exp_lat = TIMEOUT + 1; exp_en = TIMEOUT; exp_err = 1'b1; exp_rdata = 32'h0;
        end

        check_eq("req_ready_idle", 32'(bif.cpu_req_ready), 32'd1);
        bif.cpu_req_valid   = 1'b1;
        bif.cpu_req_addr    = addr;
        bif.cpu_req_bytesel = bs;
        bif.cpu_req_wdata   = wd;
        @(posedge clk);

        t = 0; en_cnt = 0; done = 1'b0; rdy_prev = 1'b0;
        got_rdata = '0; got_err = 1'b0;
        while (!done && t < TIMEOUT + 12) begin
            @(negedge clk);
            t++;
            en_obs    = bif.bus_periph_en;
            rsp_obs   = bif.cpu_rsp_valid;
            ready_obs = bif.cpu_req_ready;
            baddr_obs = bif.bus_periph_addr;
            bbs_obs   = bif.bus_periph_bytesel;
            bdin_obs  = bif.bus_periph_din;

            check_eq("req_ready_busy", 32'(ready_obs), 32'd0);
            if (en_obs != '0) begin
                en_cnt++;
                check_eq("en_onehot", 32'(en_obs), 32'(1) << sel);
                if (en_cnt == 1) begin
                    check_eq("bus_addr", 32'(baddr_obs), 32'(addr[11:0]));
                    check_eq("bus_bytesel", 32'(bbs_obs), 32'(bs));
                    check_eq("bus_din", bdin_obs, wd);
                end
            end

            // Ignored request traffic while busy; also catches any cpu_req -> bus path.
            bif.cpu_req_valid   = 1'($urandom_range(0, 1));
            bif.cpu_req_addr    = 16'($urandom);
            bif.cpu_req_bytesel = 4'($urandom);
            bif.cpu_req_wdata   = $urandom;

            fire  = (en_obs != '0) && (en_cnt == delay + 1);
            noise = $urandom & ~(32'(1) << sel);
            bif.periph_bus_ready_nxt = NSLV'(noise) | (NSLV'(fire) << sel);
            bif.periph_bus_dout = {$urandom, $urandom, $urandom, $urandom};
            if (rdy_prev) bif.periph_bus_dout[32*sel +: 32] = rd_word;
            rdy_prev = fire;

            if (rsp_obs) begin
                done      = 1'b1;
                got_rdata = bif.cpu_rsp_rdata;
                got_err   = bif.cpu_rsp_err;
                drive_quiet();
            end
        end
        if (!done) drive_quiet();

        check_eq("rsp_seen", 32'(done), 32'd1);
        check_eq("rsp_latency", 32'(t), 32'(exp_lat));
        check_eq("en_cycles", 32'(en_cnt), 32'(exp_en));
        check_eq("rsp_rdata", got_rdata, exp_rdata);
        check_eq("rsp_err", 32'(got_err), 32'(exp_err));

        @(negedge clk);
        check_eq("rsp_one_cycle", 32'(bif.cpu_rsp_valid), 32'd0);
        check_eq("ready_after_rsp", 32'(bif.cpu_req_ready), 32'd1);
        check_eq("en_after_rsp", 32'(bif.bus_periph_en), 32'd0);
    endtask

    task automatic reset_mid_access();
        int seen;
        seen = 0;
        bif.cpu_req_valid   = 1'b1;
        bif.cpu_req_addr    = 16'h2008;
        bif.cpu_req_bytesel = 4'h0;
        bif.cpu_req_wdata   = 32'h0;
        @(posedge clk);
        @(negedge clk);
        bif.cpu_req_valid = 1'b0;
        for (int i = 0; i < 4 && seen < 2; i++) begin
            if (bif.bus_periph_en != '0) seen++;
            if (seen < 2) @(negedge clk);
        end
        check_eq("rst_en_before", 32'(bif.bus_periph_en), 32'h4);
        rst_n = 1'b0;
        #1;
        check_eq("rst_en_drop", 32'(bif.bus_periph_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(bif.cpu_rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_hold_rsp", 32'(bif.cpu_rsp_valid), 32'd0);
        end
        drive_quiet();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_ready", 32'(bif.cpu_req_ready), 32'd1);
        check_eq("rst_release_rsp", 32'(bif.cpu_rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] a;
        logic [3:0]  b;
        int          d, pick;

        drive_quiet();
        #1;
        check_eq("reset_en", 32'(bif.bus_periph_en), 32'd0);
        check_eq("reset_rsp_valid", 32'(bif.cpu_rsp_valid), 32'd0);
        check_eq("reset_rsp_err", 32'(bif.cpu_rsp_err), 32'd0);
        check_eq("reset_rsp_rdata", bif.cpu_rsp_rdata, 32'd0);
        check_eq("reset_bus_addr", 32'(bif.bus_periph_addr), 32'd0);
        check_eq("reset_bus_bytesel", 32'(bif.bus_periph_bytesel), 32'd0);
        check_eq("reset_bus_din", bif.bus_periph_din, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 32'(bif.cpu_req_ready), 32'd1);

        run_txn(16'h1004, 4'h0, 32'h0, 0, 32'hA5A5_0001);
        run_txn(16'h0000, 4'hF, 32'h1234_5678, 3, 32'hDEAD_BEEF);
        run_txn(16'h3000, 4'h0, 32'h0, 255, 32'h0BAD_0BAD);
        run_txn(16'h4000, 4'h0, 32'h0, 0, 32'h1111_2222);
        run_txn(16'h2010, 4'h0, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
        run_txn(16'h1FFC, 4'h3, 32'h5555_AAAA, TIMEOUT, 32'h7777_7777);
        reset_mid_access();
        run_txn(16'h2040, 4'h0, 32'h0, 1, 32'h600D_D00D);

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            a = r[15:0];
            if ($urandom_range(0, 7) != 0) a[15:14] = 2'b00;
            b = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            pick = $urandom_range(0, 9);
            if (pick < 6)      d = $urandom_range(0, 4);
            else if (pick < 8) d = $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
            else               d = 255;
            run_txn(a, b, $urandom, d, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nanorv32_periph_bridge.md
NANORV32_PERIPH_BRIDGE -- requirements
Module: nanorv32_periph_bridge

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, giving the maximum number of cycles en is held waiting for slave ready (legal range 2..255).
REQ-002 SHALL provide parameter NSLV, default 4, giving the number of peripheral slaves (fixed decode on addr[13:12]).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req_valid  input  1  CPU request present.
REQ-006 cpu_req_ready  output  1  bridge accepts request this cycle.
REQ-007 cpu_req_addr  input  16  byte address; [15:14] must be 0, [13:12] slave select, [11:0] slave offset.
REQ-008 cpu_req_bytesel  input  4  byte enables; nonzero = write, zero = read.
REQ-009 cpu_req_wdata  input  32  write data.
REQ-010 cpu_rsp_valid  output  1  one-cycle response pulse.
REQ-011 cpu_rsp_rdata  output  32  read data, valid with cpu_rsp_valid.
REQ-012 cpu_rsp_err  output  1  decode or timeout error, valid with cpu_rsp_valid.
REQ-013 bus_periph_addr  output  12  shared slave offset.
REQ-014 bus_periph_bytesel  output  4  shared byte enables.
REQ-015 bus_periph_din  output  32  shared write data.
REQ-016 bus_periph_en  output  NSLV  one-hot slave enable.
REQ-017 periph_bus_dout  input  32*NSLV  slave read data, slave i at bits [32*i+31:32*i].
REQ-018 periph_bus_ready_nxt  input  NSLV  slave i acknowledges; its dout is valid the following cycle.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DATA, RESP; only IDLE asserts cpu_req_ready.
REQ-020 IDLE: on cpu_req_valid, SHALL latch addr/bytesel/wdata; addr[15:14]!=0 -> RESP with err=1, else -> ACCESS.
REQ-021 bus_periph_addr/bytesel/din SHALL come from latched registers only; no combinational path from cpu_req_* to bus_periph_*.
REQ-022 ACCESS: bus_periph_en[addr[13:12]] SHALL be 1, all other bits 0; en is 0 in every other state.
REQ-023 ACCESS: wait counter cleared on entry; ready_nxt[sel]=1 -> DATA; else if counter==TIMEOUT-1 -> RESP with err=1, rdata=0; else counter+1.
REQ-024 Ready on the final timeout cycle SHALL take priority over timeout (success).
REQ-025 ready_nxt bits of non-selected slaves SHALL be ignored.
REQ-026 DATA: read -> capture periph_bus_dout slice of sel into rdata; write -> rdata=0; err=0; -> RESP.
REQ-027 RESP: cpu_rsp_valid=1 for exactly one cycle with registered rdata/err, then -> IDLE; no response backpressure.
REQ-028 Latency, zero-wait slave: request accepted at cycle N -> en at N+1 -> rsp_valid at N+3.
REQ-029 Latency, decode error: rsp_valid at N+1, no en pulse.
REQ-030 One outstanding transaction maximum; cpu_req_valid outside IDLE SHALL be ignored.

Reset
REQ-031 On rst_n=0, SHALL asynchronously go to IDLE; en=0, rsp_valid=0, rsp_err=0, rdata=0, bus addr/bytesel/din=0, counter=0.
REQ-032 Reset during ACCESS SHALL drop en immediately with no response generated; cpu_req_ready=1 from first clock after release.

Verification
REQ-033 Read 0x1004, bytesel 0, slave 1 ready on first ACCESS cycle, dout1=0xA5A5_0001 -> en=4'b0010 one cycle, addr=0x004, rsp at N+3 rdata=0xA5A5_0001 err=0.
REQ-034 Write 0x0000 bytesel 4'hF wdata 0x1234_5678, slave 0 ready after 3 cycles -> en held 4 cycles, din=0x1234_5678, rsp rdata=0 err=0.
REQ-035 Read 0x3000, slave 3 never ready, TIMEOUT=16 -> en high exactly 16 cycles, rsp err=1 rdata=0.
REQ-036 Read 0x4000 -> no en, rsp at N+1 err=1; ready on cycle 16 of a TIMEOUT=16 wait -> err=0.
REQ-037 rst_n low in 2nd ACCESS cycle -> en=0 same cycle, no rsp_valid; new read after release completes normally.
